// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB 1.0 NRZI receive path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    J,
    K,
    SE0,
    SE1
  } line_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERR
  } rx_state_t;

  localparam int unsigned SYNC_LEN   = 8;
  localparam int unsigned SYNC_CNT_W = $clog2(SYNC_LEN);

  // SYNC as decoded bits, LSB received first: seven 0s then a 1
  localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'b1000_0000;

  // Map the sampled D+/D- pair onto a line class
  function automatic line_t classify_line(input logic dp, input logic dm);
    line_t cls;
    case ({dp, dm})
      2'b10:   cls = J;
      2'b01:   cls = K;
      2'b00:   cls = SE0;
      default: cls = SE1;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/usb_rx_unstuff.sv
// Bit-unstuffing: tracks the run of decoded 1s and classifies each bit as
// kept data, a dropped stuff 0, or a stuffing violation.
module usb_rx_unstuff
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_ONES = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic keep_c,
  output logic violation_c
);

  localparam int unsigned ONES_W = $clog2(MAX_ONES + 1);

  logic [ONES_W-1:0] ones_q;
  logic              at_max_c;

  // After MAX_ONES 1s the next bit must be a stuffed 0
  assign at_max_c    = (ones_q == ONES_W'(MAX_ONES));
  assign keep_c      = bit_en & ~at_max_c;
  assign violation_c = bit_en & at_max_c & bit_in;

  // Ones-run counter; a 0 or a consumed stuff bit restarts the run
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_q <= '0;
    end else if (clr) begin
      ones_q <= '0;
    end else if (bit_en) begin
      if (at_max_c || !bit_in) begin
        ones_q <= '0;
      end else begin
        ones_q <= ones_q + ONES_W'(1);
      end
    end
  end

endmodule

// File: rtl/usb_nrzi_rx.sv
// USB 1.0 receive decoder: NRZI decode, unstuffing, SYNC qualification,
// byte assembly and EOP/error detection.
// Build option: define USB_RX_SYNC_CHECK_EN to qualify the SYNC field;
// without it the K that leaves IDLE starts the data stream directly.
module usb_nrzi_rx
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_ONES    = 6,
  parameter int unsigned EOP_SE0_LEN = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dp_in,
  input  logic              dm_in,
  input  logic              sample_en,
  input  logic              restart,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              end_packet,
  output logic              error,
  output logic              stuff_error,
  output logic              busy
);

  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned SE0_W = $clog2(EOP_SE0_LEN + 1);

  rx_state_t         state_q, state_d;
  line_t             line_c, prev_q, prev_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SE0_W-1:0]  se0_cnt_q, se0_cnt_d;
  logic [DATA_W-1:0] word_q, word_d, word_shift_c;
`ifdef USB_RX_SYNC_CHECK_EN
  logic [SYNC_CNT_W-1:0] sync_cnt_q, sync_cnt_d;
`endif

  logic              step_c, is_jk_c, dbit_c, data_bit_c;
  logic              keep_c, viol_c, ones_clr_c, word_done_c, eop_ok_c;
  logic              bit_out_d, bit_valid_d, byte_valid_d, end_packet_d, stuff_error_d;
  logic [DATA_W-1:0] byte_out_d;

  // Line classification and NRZI decode against the last J/K level
  assign line_c       = classify_line(dp_in, dm_in);
  assign step_c       = sample_en & ~restart;
  assign is_jk_c      = (line_c == J) | (line_c == K);
  assign dbit_c       = (line_c == prev_q);
  assign word_shift_c = {dbit_c, word_q[DATA_W-1:1]};

`ifdef USB_RX_SYNC_CHECK_EN
  assign data_bit_c = step_c & is_jk_c & (state_q == DATA);
`else
  // The K leaving IDLE is itself the first data bit
  assign data_bit_c = step_c & is_jk_c &
                      ((state_q == DATA) | ((state_q == IDLE) & (line_c == K)));
`endif

  // No data bits flow in SYNC or EOP, so the ones run is reset there
  assign ones_clr_c = restart | (step_c & ((state_q == SYNC) | (state_q == EOP)));

  usb_rx_unstuff #(
    .MAX_ONES (MAX_ONES)
  ) u_unstuff (
    .clk         (clk),
    .n_rst       (n_rst),
    .clr         (ones_clr_c),
    .bit_en      (data_bit_c),
    .bit_in      (dbit_c),
    .keep_c      (keep_c),
    .violation_c (viol_c)
  );

  assign word_done_c = keep_c & (bit_cnt_q == BIT_W'(DATA_W - 1));
  assign eop_ok_c    = step_c & (state_q == EOP) & (line_c == J) &
                       (se0_cnt_q >= SE0_W'(EOP_SE0_LEN)) & (bit_cnt_q == '0);

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      prev_q     <= J;
      bit_cnt_q  <= '0;
      se0_cnt_q  <= '0;
      word_q     <= '0;
`ifdef USB_RX_SYNC_CHECK_EN
      sync_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      bit_cnt_q  <= bit_cnt_d;
      se0_cnt_q  <= se0_cnt_d;
      word_q     <= word_d;
`ifdef USB_RX_SYNC_CHECK_EN
      sync_cnt_q <= sync_cnt_d;
`endif
    end
  end

  // Next state and datapath; everything holds between strobes
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    bit_cnt_d  = bit_cnt_q;
    se0_cnt_d  = se0_cnt_q;
    word_d     = word_q;
`ifdef USB_RX_SYNC_CHECK_EN
    sync_cnt_d = sync_cnt_q;
`endif
    if (restart) begin
      state_d    = IDLE;
      prev_d     = J;
      bit_cnt_d  = '0;
      se0_cnt_d  = '0;
      word_d     = '0;
`ifdef USB_RX_SYNC_CHECK_EN
      sync_cnt_d = '0;
`endif
    end else if (sample_en) begin
      if (is_jk_c) begin
        prev_d = line_c;
      end
      if (keep_c) begin
        word_d    = word_shift_c;
        bit_cnt_d = word_done_c ? '0 : bit_cnt_q + BIT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (line_c == K) begin
`ifdef USB_RX_SYNC_CHECK_EN
            state_d    = (dbit_c == SYNC_PATTERN[0]) ? SYNC : ERR;
            sync_cnt_d = SYNC_CNT_W'(1);
`else
            state_d    = DATA;
`endif
          end
        end
`ifdef USB_RX_SYNC_CHECK_EN
        SYNC: begin
          if (!is_jk_c || (dbit_c != SYNC_PATTERN[sync_cnt_q])) begin
            state_d = ERR;
          end else if (sync_cnt_q == SYNC_CNT_W'(SYNC_LEN - 1)) begin
            state_d    = DATA;
            sync_cnt_d = '0;
            bit_cnt_d  = '0;
            word_d     = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + SYNC_CNT_W'(1);
          end
        end
`endif
        DATA: begin
          if (line_c == SE0) begin
            state_d   = EOP;
            se0_cnt_d = SE0_W'(1);
          end else if (line_c == SE1 || viol_c) begin
            state_d = ERR;
          end
        end
        EOP: begin
          if (line_c == SE0) begin
            if (se0_cnt_q < SE0_W'(EOP_SE0_LEN)) begin
              se0_cnt_d = se0_cnt_q + SE0_W'(1);
            end
          end else if (eop_ok_c) begin
            state_d   = IDLE;
            se0_cnt_d = '0;
          end else begin
            state_d = ERR;
          end
        end
        default: ;
      endcase
    end
  end

  // Next values of the registered outputs
  always_comb begin
    bit_out_d     = bit_out;
    bit_valid_d   = 1'b0;
    byte_out_d    = byte_out;
    byte_valid_d  = 1'b0;
    end_packet_d  = 1'b0;
    stuff_error_d = stuff_error;
    if (restart) begin
      bit_out_d     = 1'b0;
      byte_out_d    = '0;
      stuff_error_d = 1'b0;
    end else begin
      if (keep_c) begin
        bit_valid_d = 1'b1;
        bit_out_d   = dbit_c;
      end
      if (word_done_c) begin
        byte_valid_d = 1'b1;
        byte_out_d   = word_shift_c;
      end
      if (eop_ok_c) begin
        end_packet_d = 1'b1;
      end
      if (viol_c) begin
        stuff_error_d = 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      end_packet  <= 1'b0;
      error       <= 1'b0;
      stuff_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bit_out     <= bit_out_d;
      bit_valid   <= bit_valid_d;
      byte_out    <= byte_out_d;
      byte_valid  <= byte_valid_d;
      end_packet  <= end_packet_d;
      error       <= (state_d == ERR);
      stuff_error <= stuff_error_d;
      busy        <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_usb_nrzi_rx.sv
// Self-checking bench for usb_nrzi_rx: a transmitter-side model (stuffing and
// NRZI encoding of payload bytes) drives the line, and the recovered bits,
// bytes, EOPs and flags are compared with the payload.
module tb_usb_nrzi_rx;

  localparam int unsigned MAX_ONES = 6;
  localparam int unsigned DATA_W   = 8;

  logic              clk = 1'b0;
  logic              n_rst, dp_in, dm_in, sample_en, restart;
  logic              bit_out, bit_valid, byte_valid, end_packet;
  logic              error, stuff_error, busy;
  logic [DATA_W-1:0] byte_out;

  int         tests = 0;
  int         fails = 0;
  bit         line_j;
  int         ones;
  logic [7:0] pkt[$];
  bit         exp_bits[$];
  logic [7:0] exp_bytes[$];
  bit         got_bits[$];
  logic [7:0] got_bytes[$];
  int         got_eops = 0;

  always #5 clk = ~clk;

  usb_nrzi_rx #(
    .MAX_ONES    (MAX_ONES),
    .EOP_SE0_LEN (2),
    .DATA_W      (DATA_W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .dp_in       (dp_in),
    .dm_in       (dm_in),
    .sample_en   (sample_en),
    .restart     (restart),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .end_packet  (end_packet),
    .error       (error),
    .stuff_error (stuff_error),
    .busy        (busy)
  );

  // Record every pulse; a pulse wider than one cycle shows up as an extra entry
  always @(negedge clk) begin
    if (bit_valid)  got_bits.push_back(bit_out);
    if (byte_valid) got_bytes.push_back(byte_out);
    if (end_packet) got_eops++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobed line sample followed by a random idle gap
  task automatic put(input bit dp, input bit dm);
    dp_in = dp;
    dm_in = dm;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic put_line(input bit j);
    if (j) put(1'b1, 1'b0);
    else   put(1'b0, 1'b1);
  endtask

  // NRZI: a 0 toggles the line, a 1 keeps it
  task automatic send_bit(input bit b);
    if (!b) line_j = !line_j;
    put_line(line_j);
  endtask

  // Transmitter stuffing: a 0 is inserted after MAX_ONES consecutive 1s
  task automatic send_data_bit(input bit b);
    send_bit(b);
    if (b) ones++;
    else   ones = 0;
    if (ones == MAX_ONES) begin
      send_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_sync();
    logic [7:0] sp;
    sp = 8'b1000_0000;
    line_j = 1'b1;
    ones = 0;
    for (int i = 0; i < 8; i++) send_data_bit(sp[i]);
`ifdef USB_RX_SYNC_CHECK_EN
    ones = 0;
`else
    for (int i = 0; i < 8; i++) exp_bits.push_back(sp[i]);
    exp_bytes.push_back(sp);
`endif
  endtask

  task automatic send_eop();
    put(1'b0, 1'b0);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    line_j = 1'b1;
  endtask

  task automatic restart_dut();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    line_j = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bit_out"},     32'(bit_out),     0);
    chk({tag, "_bit_valid"},   32'(bit_valid),   0);
    chk({tag, "_byte_out"},    32'(byte_out),    0);
    chk({tag, "_byte_valid"},  32'(byte_valid),  0);
    chk({tag, "_end_packet"},  32'(end_packet),  0);
    chk({tag, "_error"},       32'(error),       0);
    chk({tag, "_stuff_error"}, 32'(stuff_error), 0);
    chk({tag, "_busy"},        32'(busy),        0);
  endtask

  // Full good packet: SYNC, payload in pkt, EOP; compare recovered stream
  task automatic run_packet(input string tag);
    int bb, by, eb, nbad;
    bb = got_bits.size();
    by = got_bytes.size();
    eb = got_eops;
    exp_bits.delete();
    exp_bytes.delete();
    send_sync();
    chk({tag, "_busy"}, 32'(busy), 1);
    foreach (pkt[k]) begin
      for (int i = 0; i < 8; i++) begin
        exp_bits.push_back(pkt[k][i]);
        send_data_bit(pkt[k][i]);
      end
      exp_bytes.push_back(pkt[k]);
    end
    send_eop();
    tick();
    tick();
    chk({tag, "_nbytes"}, 32'(got_bytes.size() - by), 32'(exp_bytes.size()));
    foreach (exp_bytes[i]) begin
      if (by + i < got_bytes.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[by + i]), 32'(exp_bytes[i]));
    end
    chk({tag, "_nbits"}, 32'(got_bits.size() - bb), 32'(exp_bits.size()));
    nbad = 0;
    foreach (exp_bits[i]) begin
      if (bb + i < got_bits.size() && got_bits[bb + i] != exp_bits[i]) nbad++;
    end
    chk({tag, "_bit_errs"}, 32'(nbad), 0);
    chk({tag, "_eop"},      32'(got_eops - eb), 1);
    chk({tag, "_error"},    32'(error), 0);
    chk({tag, "_idle"},     32'(busy), 0);
  endtask

  initial begin
    int eb, by;
    n_rst     = 1'b0;
    dp_in     = 1'b1;
    dm_in     = 1'b0;
    sample_en = 1'b0;
    restart   = 1'b0;
    line_j    = 1'b1;
    ones      = 0;
    tick();
    tick();
    chk_all_zero("reset");
    n_rst = 1'b1;
    tick();

    // Directed good packets
    pkt.delete();
    pkt.push_back(8'hA5);
    run_packet("a5");
    pkt.delete();
    pkt.push_back(8'hFF);
    pkt.push_back(8'h01);
    run_packet("ff01");

    // Random payloads biased toward long runs of 1s
    for (int n = 0; n < 12; n++) begin
      pkt.delete();
      repeat ($urandom_range(1, 4))
        pkt.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
      run_packet($sformatf("rnd%0d", n));
    end

    // Seven 1s with no stuffed 0: sticky stuff error
    eb = got_eops;
    send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    tick();
    chk("stuff_err_error", 32'(error), 1);
    chk("stuff_err_flag",  32'(stuff_error), 1);
    put(1'b0, 1'b1);
    send_eop();
    chk("stuff_err_held",  32'(error), 1);
    chk("stuff_err_fheld", 32'(stuff_error), 1);
    chk("stuff_err_noeop", 32'(got_eops - eb), 0);
    restart_dut();
    chk("stuff_err_clr",   32'(stuff_error), 0);
    chk("stuff_err_eclr",  32'(error), 0);

    // EOP on a partial word
    eb = got_eops;
    send_sync();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_eop();
    tick();
    chk("partial_eop_error", 32'(error), 1);
    chk("partial_eop_noeop", 32'(got_eops - eb), 0);
    chk("partial_eop_nostf", 32'(stuff_error), 0);
    restart_dut();

    // Single SE0 on a byte boundary
    eb = got_eops;
    send_sync();
    for (int i = 0; i < 8; i++) send_data_bit(i[0]);
    put(1'b0, 1'b0);
    put(1'b1, 1'b0);
    tick();
    chk("short_se0_error", 32'(error), 1);
    chk("short_se0_noeop", 32'(got_eops - eb), 0);
    restart_dut();

    // SE1 in DATA
    send_sync();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    put(1'b1, 1'b1);
    tick();
    chk("se1_error", 32'(error), 1);
    chk("se1_nostf", 32'(stuff_error), 0);
    restart_dut();

    // restart wins over a simultaneous sample
    send_sync();
    for (int i = 0; i < 8; i++) send_data_bit(i == 0 || i == 2 || i == 5 || i == 7);
    send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
    chk("pre_restart_byte", 32'(byte_out), 32'h0000_00A5);
    chk("pre_restart_bit",  32'(bit_out), 1);
    chk("pre_restart_busy", 32'(busy), 1);
    dp_in = 1'b0;
    dm_in = 1'b1;
    sample_en = 1'b1;
    restart = 1'b1;
    tick();
    sample_en = 1'b0;
    restart = 1'b0;
    line_j = 1'b1;
    chk_all_zero("restart");
    pkt.delete();
    pkt.push_back(8'h3C);
    run_packet("post_restart");

    // Reset mid-packet drops the partial word silently
    eb = got_eops;
    send_sync();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    by = got_bytes.size();
    #2 n_rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    n_rst = 1'b1;
    line_j = 1'b1;
    tick();
    tick();
    chk("midrst_nobyte", 32'(got_bytes.size() - by), 0);
    chk("midrst_noeop",  32'(got_eops - eb), 0);
    pkt.delete();
    pkt.push_back(8'hC3);
    run_packet("post_midrst");

`ifndef USB_RX_SYNC_CHECK_EN
    // K then seven J: expected word from plain NRZI decoding of the samples
    begin
      bit         smp[8];
      bit         prev;
      logic [7:0] want;
      smp[0] = 1'b0;
      for (int i = 1; i < 8; i++) smp[i] = 1'b1;
      prev = 1'b1;
      want = '0;
      for (int i = 0; i < 8; i++) begin
        want[i] = (smp[i] == prev);
        prev = smp[i];
      end
      eb = got_eops;
      by = got_bytes.size();
      for (int i = 0; i < 8; i++) put_line(smp[i]);
      send_eop();
      tick();
      tick();
      chk("kj7_nbytes", 32'(got_bytes.size() - by), 1);
      if (got_bytes.size() > by)
        chk("kj7_byte", 32'(got_bytes[by]), 32'(want));
      chk("kj7_eop", 32'(got_eops - eb), 1);
      chk("kj7_error", 32'(error), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
